inverter_nbit_stream: RTL and testbench
=======================================

# inverter_nbit_stream

Parametrised, streaming successor to the 1-bit conditional inverter: a WIDTH-bit datapath that passes, bitwise-inverts or two's-complement-negates each word according to a per-word mode, behind a valid/ready handshake. Results are held in a 2-entry output buffer, which gives full throughput and back-pressure tolerance. A saturating counter tracks how many modified words have been delivered. It sits between a producer and consumer in the bench datapaths wherever a conditionally-inverted bus must be registered and flow-controlled.

## Interface
- WIDTH, 8, data width in bits (≥2)
- CNT_W, 16, width of the modified-word counter

- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  producer has a word
- in_ready  output  1  block can accept a word
- in_data  input  WIDTH  input word
- in_mode  input  2  00 pass, 01 invert, 10 negate, 11 pass (reserved)
- out_valid  output  1  head word available
- out_ready  input  1  consumer accepts head word
- out_data  output  WIDTH  transformed head word
- out_ovf  output  1  head word was a negate of the most-negative value
- mod_count  output  CNT_W  number of delivered words with mode 01/10, saturating

## Operation
- Push: in_valid && in_ready at a rising edge. The transform is computed at push time and stored with its ovf flag and a "modified" flag.
- Transforms:
  - 00/11: y = x.
  - 01: y = ~x.
  - 10: y = ~x + 1, modulo 2^WIDTH.
- out_ovf is 1 only for mode 10 with x = 1 followed by WIDTH-1 zeros (e.g. 0x80). In that case y = x.
- Negate of 0 gives 0 with ovf = 0.
- Buffer: 2-entry FIFO with occupancy count 0..2.
  - in_ready = (count != 2). It is a function of registered state only and never depends on out_ready.
  - out_valid = (count != 0). out_data and out_ovf come from the head entry and are held stable while out_valid && !out_ready.
- Pop: out_valid && out_ready at a rising edge.
- Simultaneous push and pop at count 1: count stays 1, the new word becomes head, and order is preserved.
- mod_count increments by 1 on a pop whose entry was flagged modified. It saturates at all-ones and does not wrap.
- mode 11 is never counted as modified.
- Reset (asynchronous, any time including mid-transfer):
  - count = 0, out_valid = 0, in_ready = 1, out_data = 0, out_ovf = 0, mod_count = 0.
  - Buffered words are discarded.

## Timing
- Latency: a word pushed at edge k is on out_data with out_valid = 1 immediately after edge k, provided the buffer was empty.
- Throughput: one word per cycle while out_ready = 1. Occupancy stays at 1 in steady state.
- Back-pressure: with out_ready = 0, two words are accepted. in_ready drops after the second push edge.
- After a pop at count 2, in_ready rises the following cycle, i.e. after that edge.
- mod_count updates on the same edge as the counted pop.
- No combinational path from in_* to out_*, and none from out_ready to in_ready.

## Configuration
- INVERTER_NEG_EN defined: mode 10 performs two's-complement negate and out_ovf operates as described.
- INVERTER_NEG_EN undefined:
  - mode 10 behaves exactly as mode 01 (invert) and is still counted as modified.
  - out_ovf is tied to 0.
  - No adder is synthesised.

## Test plan
- Reset, then push 0x5A in mode 01 with out_ready = 1 → next cycle out_data = 0xA5, out_valid = 1, mod_count = 1 after the pop edge.
- With INVERTER_NEG_EN, push 0x80, 0x01 and 0x00 in mode 10 back-to-back with out_ready = 1 → outputs 0x80 (ovf = 1), 0xFF (ovf = 0), 0x00 (ovf = 0). One word per cycle; mod_count = 3.
- out_ready = 0, push 0x11, 0x22, 0x33 in mode 00 continuously → in_ready falls after the 2nd push. 0x33 is held until out_ready = 1. The outputs are then 0x11, 0x22, 0x33 in order, and mod_count = 0.
- Mode 11 with 0xF0 → out_data = 0xF0 and mod_count unchanged. Without INVERTER_NEG_EN, mode 10 with 0x80 → 0x7F with ovf = 0.
- Assert rst_n low while count = 2 → immediately out_valid = 0, in_ready = 1, mod_count = 0. After release, the next pushed word is the first output.
- Force mod_count near saturation (CNT_W = 4, 17 modified pops) → mod_count stays at 0xF.

Source files
------------

// File: rtl/inverter_nbit_stream.sv
// rtl/inverter_nbit_stream.sv - streaming pass/invert/negate datapath with 2-entry output buffer
// Optional two's-complement negate for mode 10 is enabled by defining INVERTER_NEG_EN.
module inverter_nbit_stream #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic [1:0]       in_mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_ovf,
   output logic [CNT_W-1:0] mod_count
);

   localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

   logic [WIDTH-1:0] data0_q, data0_d, data1_q, data1_d;
   logic             ovf0_q, ovf0_d, ovf1_q, ovf1_d;
   logic             mod0_q, mod0_d, mod1_q, mod1_d;
   logic [1:0]       count_q, count_d;
   logic [CNT_W-1:0] mod_count_q, mod_count_d;

   logic [WIDTH-1:0] xf_data;
   logic             xf_ovf;
   logic             xf_mod;
   logic             push;
   logic             pop;

   // Transform is evaluated at push time so the buffer holds finished results.
   always_comb begin
      xf_data = in_data;
      xf_ovf  = 1'b0;
      xf_mod  = (in_mode == 2'b01) || (in_mode == 2'b10);
      case (in_mode)
         2'b01: xf_data = ~in_data;
         2'b10: begin
`ifdef INVERTER_NEG_EN
            xf_data = ~in_data + {{(WIDTH-1){1'b0}}, 1'b1};
            xf_ovf  = (in_data == MOST_NEG);
`else
            xf_data = ~in_data;
`endif
         end
         default: xf_data = in_data;
      endcase
   end

   assign in_ready  = (count_q != 2'd2);
   assign out_valid = (count_q != 2'd0);
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;

   always_comb begin
      data0_d     = data0_q;
      data1_d     = data1_q;
      ovf0_d      = ovf0_q;
      ovf1_d      = ovf1_q;
      mod0_d      = mod0_q;
      mod1_d      = mod1_q;
      count_d     = count_q + {1'b0, push} - {1'b0, pop};
      mod_count_d = mod_count_q;

      if (pop) begin
         data0_d = data1_q;
         ovf0_d  = ovf1_q;
         mod0_d  = mod1_q;
         if (mod0_q && (mod_count_q != CNT_MAX)) begin
            mod_count_d = mod_count_q + CNT_ONE;
         end
      end

      // New word lands behind whatever survives this edge's pop.
      if (push) begin
         if ((count_q == 2'd1) && !pop) begin
            data1_d = xf_data;
            ovf1_d  = xf_ovf;
            mod1_d  = xf_mod;
         end else begin
            data0_d = xf_data;
            ovf0_d  = xf_ovf;
            mod0_d  = xf_mod;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data0_q     <= '0;
         data1_q     <= '0;
         ovf0_q      <= 1'b0;
         ovf1_q      <= 1'b0;
         mod0_q      <= 1'b0;
         mod1_q      <= 1'b0;
         count_q     <= 2'd0;
         mod_count_q <= '0;
      end else begin
         data0_q     <= data0_d;
         data1_q     <= data1_d;
         ovf0_q      <= ovf0_d;
         ovf1_q      <= ovf1_d;
         mod0_q      <= mod0_d;
         mod1_q      <= mod1_d;
         count_q     <= count_d;
         mod_count_q <= mod_count_d;
      end
   end

   assign out_data  = data0_q;
`ifdef INVERTER_NEG_EN
   assign out_ovf   = ovf0_q;
`else
   assign out_ovf   = 1'b0;
`endif
   assign mod_count = mod_count_q;

endmodule

// File: tb/tb_inverter_nbit_stream.sv
// tb/tb_inverter_nbit_stream.sv - directed self-checking bench for inverter_nbit_stream
// Expectations follow INVERTER_NEG_EN when it is defined for the build.
module tb_inverter_nbit_stream;

   localparam int WIDTH = 8;
   localparam int CNT_W = 4;

   logic             clk;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic [1:0]       in_mode;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;
   logic             out_ovf;
   logic [CNT_W-1:0] mod_count;

   int n_cmp = 0;
   int n_mis = 0;

   inverter_nbit_stream #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_mode   (in_mode),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_ovf   (out_ovf),
      .mod_count (mod_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   logic [7:0] neg_in  [3];
   logic [7:0] neg_out [3];
   logic       neg_ovf [3];

   initial begin
      neg_in[0] = 8'h80; neg_in[1] = 8'h01; neg_in[2] = 8'h00;
`ifdef INVERTER_NEG_EN
      neg_out[0] = 8'h80; neg_out[1] = 8'hFF; neg_out[2] = 8'h00;
      neg_ovf[0] = 1'b1;  neg_ovf[1] = 1'b0;  neg_ovf[2] = 1'b0;
`else
      neg_out[0] = 8'h7F; neg_out[1] = 8'hFE; neg_out[2] = 8'hFF;
      neg_ovf[0] = 1'b0;  neg_ovf[1] = 1'b0;  neg_ovf[2] = 1'b0;
`endif

      rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_mode = 2'b00; out_ready = 1'b0;
      step();
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_out_data", 32'(out_data), 32'd0);
      check("rst_out_ovf", 32'(out_ovf), 32'd0);
      check("rst_mod_count", 32'(mod_count), 32'd0);
      rst_n = 1'b1;
      step();

      // invert 0x5A
      in_valid = 1'b1; in_data = 8'h5A; in_mode = 2'b01; out_ready = 1'b1;
      step();
      in_valid = 1'b0;
      check("inv_data", 32'(out_data), 32'hA5);
      check("inv_valid", 32'(out_valid), 32'd1);
      check("inv_cnt_before_pop", 32'(mod_count), 32'd0);
      step();
      check("inv_cnt_after_pop", 32'(mod_count), 32'd1);
      check("inv_drained", 32'(out_valid), 32'd0);

      // mode 10 back-to-back, one word per cycle
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1; in_data = neg_in[i]; in_mode = 2'b10;
         step();
         check("neg_data", 32'(out_data), 32'(neg_out[i]));
         check("neg_ovf", 32'(out_ovf), 32'(neg_ovf[i]));
         check("neg_in_ready", 32'(in_ready), 32'd1);
         check("neg_cnt", 32'(mod_count), 32'(1 + i));
      end
      in_valid = 1'b0;
      step();
      check("neg_cnt_final", 32'(mod_count), 32'd4);
      check("neg_drained", 32'(out_valid), 32'd0);

      // back-pressure
      out_ready = 1'b0;
      in_valid = 1'b1; in_data = 8'h11; in_mode = 2'b00;
      step();
      check("bp_head1", 32'(out_data), 32'h11);
      check("bp_ready1", 32'(in_ready), 32'd1);
      in_data = 8'h22;
      step();
      check("bp_ready2", 32'(in_ready), 32'd0);
      check("bp_head2", 32'(out_data), 32'h11);
      in_data = 8'h33;
      step();
      check("bp_ready_held", 32'(in_ready), 32'd0);
      check("bp_head_held", 32'(out_data), 32'h11);
      out_ready = 1'b1;
      step();
      check("bp_out2", 32'(out_data), 32'h22);
      check("bp_ready_rise", 32'(in_ready), 32'd1);
      step();
      in_valid = 1'b0;
      check("bp_out3", 32'(out_data), 32'h33);
      step();
      check("bp_drained", 32'(out_valid), 32'd0);
      check("bp_cnt", 32'(mod_count), 32'd4);

      // reserved mode 11 passes and is not counted
      in_valid = 1'b1; in_data = 8'hF0; in_mode = 2'b11;
      step();
      in_valid = 1'b0;
      check("m11_data", 32'(out_data), 32'hF0);
      check("m11_ovf", 32'(out_ovf), 32'd0);
      step();
      check("m11_cnt", 32'(mod_count), 32'd4);

      // saturation: 11 more modified words reach 0xF, 2 more stay there
      in_valid = 1'b1; in_mode = 2'b01;
      for (int i = 0; i < 11; i++) begin
         in_data = 8'(i);
         step();
      end
      in_valid = 1'b0;
      step();
      check("sat_reach", 32'(mod_count), 32'hF);
      in_valid = 1'b1; in_mode = 2'b10;
      for (int i = 0; i < 2; i++) begin
         in_data = 8'h40;
         step();
      end
      in_valid = 1'b0;
      step();
      check("sat_hold", 32'(mod_count), 32'hF);

      // asynchronous reset while full
      out_ready = 1'b0;
      in_valid = 1'b1; in_mode = 2'b00; in_data = 8'hAA;
      step();
      in_data = 8'hBB;
      step();
      in_valid = 1'b0;
      check("full_ready", 32'(in_ready), 32'd0);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_out_valid", 32'(out_valid), 32'd0);
      check("arst_in_ready", 32'(in_ready), 32'd1);
      check("arst_mod_count", 32'(mod_count), 32'd0);
      check("arst_out_data", 32'(out_data), 32'd0);
      step();
      rst_n = 1'b1;
      out_ready = 1'b1;
      in_valid = 1'b1; in_data = 8'h3C; in_mode = 2'b00;
      step();
      in_valid = 1'b0;
      check("post_rst_first", 32'(out_data), 32'h3C);
      check("post_rst_valid", 32'(out_valid), 32'd1);
      step();
      check("post_rst_drained", 32'(out_valid), 32'd0);
      check("post_rst_cnt", 32'(mod_count), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
